// File: rtl/mmio_console_in.sv
// -----------------------------------------------------------------------------
// mmio_console_in
//
// Memory-mapped console responder for a four-word window on the core's data
// request bus. Host characters are queued in an RX FIFO and popped by reads of
// RX_DATA. A STATUS register reports the FIFO fill level. Writes to TX_DATA are
// re-issued as a one-cycle character strobe. Responses are registered one cycle
// after a selected request, matching data_mem timing.
//
// Register map (by addr[3:2]):
//   0x0 RX_DATA  read pops head; 32'hFFFF_FFFF when empty
//   0x4 STATUS   {16'b0, count[7:0], 6'b0, tx_ready=1, !empty}
//   0x8 TX_DATA  write lane 0 -> tx strobe
//   0xC reserved reads 0, writes ignored
//
// Ports:
//   clk            clock
//   reset          synchronous, active-high reset
//   req            core data request (valid, addr, data, do_read, do_write)
//   rsp            registered response (valid, addr, data)
//   hit            registered; high when rsp.valid is driven by this block
//   host_rx_valid  host offers a character
//   host_rx_data   character byte
//   host_rx_ready  FIFO can accept (not full)
//   tx_valid       one-cycle strobe, console character written
//   tx_data        character, valid with tx_valid
// -----------------------------------------------------------------------------

package mmio_console_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  do_read;
    logic [3:0]  do_write;
  } memory_io_req;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
  } memory_io_rsp;

endpackage

module mmio_console_in
  import mmio_console_pkg::*;
#(
  parameter int unsigned rx_depth  = 16,
  parameter logic [31:0] base_addr = 32'h0002_FFF0
) (
  input  logic         clk,
  input  logic         reset,
  input  memory_io_req req,
  output memory_io_rsp rsp,
  output logic         hit,
  input  logic         host_rx_valid,
  input  logic [7:0]   host_rx_data,
  output logic         host_rx_ready,
  output logic         tx_valid,
  output logic [7:0]   tx_data
);

  localparam int AW = $clog2(rx_depth);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    REG_RX     = 2'd0,
    REG_STATUS = 2'd1,
    REG_TX     = 2'd2,
    REG_RSVD   = 2'd3
  } reg_e;

  logic [7:0]    r_mem [rx_depth];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  memory_io_rsp  r_rsp;
  logic          r_hit;
  logic          r_tx_valid;
  logic [7:0]    r_tx_data;

  logic          w_sel;
  logic          w_is_read;
  logic          w_is_write;
  reg_e          w_reg;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_tx_fire;
  logic [15:0]   w_count_wide;
  logic [31:0]   w_rdata;
  logic          w_unused;

  // Bits of the request that no register decodes.
  assign w_unused = &{1'b0, req.data[31:8], req.addr[1:0]};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    w_rdata      = '0;
    w_sel        = req.valid && (req.addr[31:4] == base_addr[31:4]);
    w_is_read    = |req.do_read;
    // A combined read/write is handled as a read only.
    w_is_write   = (|req.do_write) && !w_is_read;
    w_reg        = reg_e'(req.addr[3:2]);
    w_empty      = (r_count == '0);
    w_full       = (r_count == CW'(rx_depth));
    w_pop        = w_sel && w_is_read && (w_reg == REG_RX) && !w_empty;
    // Readiness comes from the registered count only: a same-cycle pop does
    // not open a slot for a push while full.
    w_push       = host_rx_valid && !w_full;
    w_tx_fire    = w_sel && w_is_write && (w_reg == REG_TX) && req.do_write[0];
    w_count_wide = 16'(r_count);

    if (w_is_read) begin
      unique case (w_reg)
        REG_RX:     w_rdata = w_empty ? 32'hFFFF_FFFF : {24'b0, r_mem[r_rd_ptr]};
        REG_STATUS: w_rdata = {16'b0, w_count_wide[7:0], 6'b0, 1'b1, !w_empty};
        REG_TX:     w_rdata = '0;
        REG_RSVD:   w_rdata = '0;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; pointers and count define
  // which entries are meaningful, and resetting a RAM costs muxes on every bit.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= host_rx_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rsp      <= '0;
      r_hit      <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);

      r_rsp.valid <= w_sel;
      r_hit       <= w_sel;
      if (w_sel) begin
        r_rsp.addr <= req.addr;
        r_rsp.data <= w_rdata;
      end

      r_tx_valid <= w_tx_fire;
      if (w_tx_fire) r_tx_data <= req.data[7:0];
    end
  end

  assign rsp           = r_rsp;
  assign hit           = r_hit;
  assign host_rx_ready = !w_full;
  assign tx_valid      = r_tx_valid;
  assign tx_data       = r_tx_data;

endmodule

// File: tb/tb_mmio_console_in.sv
// -----------------------------------------------------------------------------
// tb_mmio_console_in
//
// Directed bench for mmio_console_in: a table of one-cycle vectors with
// hand-computed expectations, plus hand-written sequences for FIFO full/wrap
// and reset during a pop.
// -----------------------------------------------------------------------------

module tb_mmio_console_in;
  import mmio_console_pkg::*;

  localparam logic [31:0] A_RX   = 32'h0002_FFF0;
  localparam logic [31:0] A_STAT = 32'h0002_FFF4;
  localparam logic [31:0] A_TX   = 32'h0002_FFF8;
  localparam logic [31:0] A_RSVD = 32'h0002_FFFC;
  localparam logic [31:0] A_FAR  = 32'h0002_1000;
  localparam logic [31:0] EOF    = 32'hFFFF_FFFF;

  logic         clk;
  logic         reset;
  memory_io_req req;
  memory_io_rsp rsp;
  logic         hit;
  logic         host_rx_valid;
  logic [7:0]   host_rx_data;
  logic         host_rx_ready;
  logic         tx_valid;
  logic [7:0]   tx_data;

  int n_checks = 0;
  int n_errors = 0;

  mmio_console_in dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .rsp           (rsp),
    .hit           (hit),
    .host_rx_valid (host_rx_valid),
    .host_rx_data  (host_rx_data),
    .host_rx_ready (host_rx_ready),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request cycle from a negedge, let the posedge take it, and
  // return at the following negedge where the registered response is stable.
  task automatic step(input logic [31:0] addr, input logic [3:0] rd,
                      input logic [3:0] wr, input logic [31:0] wdata,
                      input logic hv, input logic [7:0] hd, input logic rst);
    reset            = rst;
    req.valid        = |{rd, wr};
    req.addr         = addr;
    req.data         = wdata;
    req.do_read      = rd;
    req.do_write     = wr;
    host_rx_valid    = hv;
    host_rx_data     = hd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read_rx(input string name, input logic [31:0] exp);
    step(A_RX, 4'h1, 4'h0, '0, 1'b0, '0, 1'b0);
    check({name, " valid"}, 32'(rsp.valid), 32'd1);
    check({name, " data"}, rsp.data, exp);
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic [31:0] wdata;
    logic        hv;
    logic [7:0]  hd;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_txv;
    logic [7:0]  exp_txd;
    logic        exp_ready;
  } vec_t;

  vec_t vecs [17];

  initial begin
    reset         = 1'b1;
    req           = '0;
    host_rx_valid = 1'b0;
    host_rx_data  = '0;

    //               name          addr    rd    wr    wdata          hv  hd     v   data          txv txd    rdy
    vecs[0]  = '{"stat_reset",   A_STAT, 4'h1, 4'h0, 32'h0,         0, 8'h00, 1, 32'h0000_0002, 0, 8'h00, 1};
    vecs[1]  = '{"rx_empty",     A_RX,   4'hF, 4'h0, 32'h0,         0, 8'h00, 1, EOF,           0, 8'h00, 1};
    vecs[2]  = '{"push_H",       A_RX,   4'h0, 4'h0, 32'h0,         1, 8'h48, 0, 32'h0,         0, 8'h00, 1};
    vecs[3]  = '{"push_i",       A_RX,   4'h0, 4'h0, 32'h0,         1, 8'h69, 0, 32'h0,         0, 8'h00, 1};
    vecs[4]  = '{"stat_two",     A_STAT, 4'h1, 4'h0, 32'h0,         0, 8'h00, 1, 32'h0000_0203, 0, 8'h00, 1};
    vecs[5]  = '{"rx_H",         A_RX,   4'h1, 4'h0, 32'h0,         0, 8'h00, 1, 32'h0000_0048, 0, 8'h00, 1};
    vecs[6]  = '{"rx_i",         A_RX,   4'h1, 4'h0, 32'h0,         0, 8'h00, 1, 32'h0000_0069, 0, 8'h00, 1};
    vecs[7]  = '{"rx_eof",       A_RX,   4'h1, 4'h0, 32'h0,         0, 8'h00, 1, EOF,           0, 8'h00, 1};
    vecs[8]  = '{"stat_empty",   A_STAT, 4'h1, 4'h0, 32'h0,         0, 8'h00, 1, 32'h0000_0002, 0, 8'h00, 1};
    vecs[9]  = '{"tx_lane0",     A_TX,   4'h0, 4'h1, 32'h1234_5641, 0, 8'h00, 1, 32'h0,         1, 8'h41, 1};
    vecs[10] = '{"tx_lane1",     A_TX,   4'h0, 4'h2, 32'h1234_5641, 0, 8'h00, 1, 32'h0,         0, 8'h00, 1};
    vecs[11] = '{"b2b_stat",     A_STAT, 4'h1, 4'h0, 32'h0,         0, 8'h00, 1, 32'h0000_0002, 0, 8'h00, 1};
    vecs[12] = '{"b2b_rx",       A_RX,   4'h1, 4'h0, 32'h0,         0, 8'h00, 1, EOF,           0, 8'h00, 1};
    vecs[13] = '{"b2b_far_wr",   A_FAR,  4'h0, 4'h1, 32'h0000_0055, 0, 8'h00, 0, 32'h0,         0, 8'h00, 1};
    vecs[14] = '{"rsvd_read",    A_RSVD, 4'h1, 4'h0, 32'h0,         0, 8'h00, 1, 32'h0,         0, 8'h00, 1};
    vecs[15] = '{"rd_wr_tx",     A_TX,   4'h1, 4'h1, 32'h0000_0077, 0, 8'h00, 1, 32'h0,         0, 8'h00, 1};
    vecs[16] = '{"wr_rx_drop",   A_RX,   4'h0, 4'h1, 32'h0000_0033, 0, 8'h00, 1, 32'h0,         0, 8'h00, 1};

    // Reset state.
    @(negedge clk);
    step('0, 4'h0, 4'h0, '0, 1'b0, '0, 1'b1);
    step('0, 4'h0, 4'h0, '0, 1'b0, '0, 1'b1);
    check("reset rsp.valid", 32'(rsp.valid), 32'd0);
    check("reset hit", 32'(hit), 32'd0);
    check("reset tx_valid", 32'(tx_valid), 32'd0);
    check("reset tx_data", 32'(tx_data), 32'd0);
    check("reset rsp.data", rsp.data, 32'd0);
    check("reset rsp.addr", rsp.addr, 32'd0);
    step('0, 4'h0, 4'h0, '0, 1'b0, '0, 1'b0);
    check("reset host_rx_ready", 32'(host_rx_ready), 32'd1);

    // Table vectors, one request per consecutive cycle.
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata,
           vecs[i].hv, vecs[i].hd, 1'b0);
      check({vecs[i].name, " rsp.valid"}, 32'(rsp.valid), 32'(vecs[i].exp_valid));
      check({vecs[i].name, " hit"}, 32'(hit), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check({vecs[i].name, " rsp.data"}, rsp.data, vecs[i].exp_data);
        check({vecs[i].name, " rsp.addr"}, rsp.addr, vecs[i].addr);
      end
      check({vecs[i].name, " tx_valid"}, 32'(tx_valid), 32'(vecs[i].exp_txv));
      if (vecs[i].exp_txv) begin
        check({vecs[i].name, " tx_data"}, 32'(tx_data), 32'(vecs[i].exp_txd));
      end
      check({vecs[i].name, " ready"}, 32'(host_rx_ready), 32'(vecs[i].exp_ready));
    end

    // Fill the FIFO with 0x00..0x0F.
    for (int i = 0; i < 16; i++) begin
      step('0, 4'h0, 4'h0, '0, 1'b1, 8'(i), 1'b0);
      check($sformatf("fill%0d ready", i), 32'(host_rx_ready), (i == 15) ? 32'd0 : 32'd1);
    end
    step(A_STAT, 4'h1, 4'h0, '0, 1'b0, '0, 1'b0);
    check("stat_full", rsp.data, 32'h0000_1003);

    // Pop while full with a push held: push refused this cycle.
    step(A_RX, 4'h1, 4'h0, '0, 1'b1, 8'h10, 1'b0);
    check("full_pop data", rsp.data, 32'h0000_0000);
    check("full_pop ready", 32'(host_rx_ready), 32'd1);
    step('0, 4'h0, 4'h0, '0, 1'b1, 8'h10, 1'b0);
    check("late_push ready", 32'(host_rx_ready), 32'd0);

    // Drain: order must be 0x01..0x0F, 0x10 across the pointer wrap.
    for (int i = 0; i < 16; i++) begin
      read_rx($sformatf("drain%0d", i), 32'(i + 1));
    end
    read_rx("drain_eof", EOF);

    // Reset asserted during an RX_DATA read with bytes queued.
    for (int i = 0; i < 3; i++) begin
      step('0, 4'h0, 4'h0, '0, 1'b1, 8'hA1 + 8'(i), 1'b0);
    end
    step(A_RX, 4'h1, 4'h0, '0, 1'b0, '0, 1'b1);
    check("rst_rd rsp.valid", 32'(rsp.valid), 32'd0);
    check("rst_rd hit", 32'(hit), 32'd0);
    step(A_STAT, 4'h1, 4'h0, '0, 1'b0, '0, 1'b0);
    check("rst_rd stat valid", 32'(rsp.valid), 32'd1);
    check("rst_rd stat", rsp.data, 32'h0000_0002);
    read_rx("rst_rd rx", EOF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
